// File: rtl/lc3b_mem_pkg.sv
// lc3b_mem_pkg: shared state, size, port and byte-enable encodings for the memory arbiter
package lc3b_mem_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: write byte replication, byte enables, read lane select and extension
module mem_lane_align
    import lc3b_mem_pkg::*;
(
    input  logic        addr_lsb,
    input  logic        size,
    input  logic        sext,
    input  logic [15:0] wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    output logic [15:0] rdata
);
    logic [7:0] lane;
    always_comb begin
        lane = addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0];
        mem_wdata = size == SIZE_WORD ? wdata : {2{wdata[7:0]}};
        mem_be = size == SIZE_WORD ? BE_WORD : addr_lsb ? BE_HI : BE_LO;
        rdata = size == SIZE_WORD ? mem_rdata : {{8{sext & lane[7]}}, lane};
    end
endmodule

// File: rtl/mem_arbiter_lsb.sv
// mem_arbiter_lsb: arbitrates fetch and data ports onto one memory port with lane steering and timeout
module mem_arbiter_lsb
    import lc3b_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TIMEOUT = 15,
    parameter int FAIR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic              d_size,
    input  logic              d_sext,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [1:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t state, state_n;
    logic port_q, we_q, size_q, sext_q;
    logic [ADDR_W-1:0] addr_q, sel_addr, mem_addr_n;
    logic [DATA_W-1:0] wdata_q, sel_wdata, al_wdata, al_rdata, rdata_n, mem_wdata_n;
    logic [FW-1:0] fair_cnt;
    logic [TW-1:0] tcnt;
    logic [1:0] al_be, mem_be_n;
    logic idle, grant, gport, sel_port, sel_we, sel_size, sel_sext, misalign;
    logic go_access, stay, to_resp, strobe_n;
    logic f_ack_n, d_ack_n, err_n, mem_rd_n, mem_wr_n;

    // In IDLE the aligner sees the port about to be granted; afterwards, the latched request.
    always_comb begin
        idle = state == IDLE;
        grant = f_req | d_req;
        gport = (d_req && !(f_req && fair_cnt == FAIR_MAX)) ? PORT_D : PORT_F;
        sel_port = idle ? gport : port_q;
        sel_addr = idle ? (gport == PORT_D ? d_addr : f_addr) : addr_q;
        sel_we = idle ? (gport == PORT_D && d_we) : we_q;
        sel_size = idle ? (gport == PORT_D ? d_size : SIZE_WORD) : size_q;
        sel_sext = idle ? (gport == PORT_D && d_sext) : sext_q;
        sel_wdata = idle ? (gport == PORT_D ? d_wdata : '0) : wdata_q;
        misalign = sel_size == SIZE_WORD && sel_addr[0];
    end

    mem_lane_align u_align (
        .addr_lsb (sel_addr[0]),
        .size     (sel_size),
        .sext     (sel_sext),
        .wdata    (sel_wdata),
        .mem_rdata(mem_rdata),
        .mem_wdata(al_wdata),
        .mem_be   (al_be),
        .rdata    (al_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = idle ? (!grant ? IDLE : misalign ? RESP : ACCESS)
                : state == ACCESS ? ((mem_ready || tcnt == T_LAST) ? RESP : ACCESS)
                : IDLE;
    end

    always_comb begin
        go_access = idle && grant && !misalign;
        stay = state == ACCESS && !mem_ready && tcnt != T_LAST;
        to_resp = state != RESP && state_n == RESP;
        strobe_n = go_access || stay;
        mem_rd_n = strobe_n && !sel_we;
        mem_wr_n = strobe_n && sel_we;
        mem_be_n = strobe_n ? al_be : '0;
        mem_addr_n = strobe_n ? {sel_addr[ADDR_W-1:1], sel_addr[0] && sel_size == SIZE_BYTE} : '0;
        mem_wdata_n = strobe_n ? al_wdata : '0;
        f_ack_n = to_resp && sel_port == PORT_F;
        d_ack_n = to_resp && sel_port == PORT_D;
        err_n = to_resp && !(state == ACCESS && mem_ready);
        rdata_n = (to_resp && state == ACCESS && mem_ready && !sel_we) ? al_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            err <= 1'b0;
            rdata <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            mem_be <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            fair_cnt <= '0;
            tcnt <= '0;
            port_q <= PORT_F;
            we_q <= 1'b0;
            size_q <= SIZE_BYTE;
            sext_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
        end else begin
            f_ack <= f_ack_n;
            d_ack <= d_ack_n;
            err <= err_n;
            rdata <= rdata_n;
            mem_rd <= mem_rd_n;
            mem_wr <= mem_wr_n;
            mem_be <= mem_be_n;
            mem_addr <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            tcnt <= stay ? tcnt + 1'b1 : '0;
            if (idle) fair_cnt <= (f_req && gport == PORT_D) ? fair_cnt + 1'b1 : '0;
            if (idle && grant) begin
                port_q <= gport;
                we_q <= sel_we;
                size_q <= sel_size;
                sext_q <= sel_sext;
                addr_q <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter_lsb.sv
// tb_mem_arbiter_lsb: scoreboard bench with a word-array memory reference model
module tb_mem_arbiter_lsb;
    import lc3b_mem_pkg::*;

    logic clk, reset, f_req, f_ack, d_req, d_we, d_size, d_sext, d_ack, err, mem_rd, mem_wr, mem_ready;
    logic [15:0] f_addr, d_addr, d_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0] mem_be;

    typedef struct {logic chk; logic err; logic [15:0] rdata;} exp_t;
    exp_t qf[$], qd[$], mon_e;
    logic [15:0] mem_arr [0:32767];
    logic [15:0] ref_mem [0:32767];
    int checks = 0, passes = 0;
    bit rnd_mode = 0;

    mem_arbiter_lsb dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_size(d_size), .d_sext(d_sext),
        .d_wdata(d_wdata), .d_ack(d_ack), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_arr[mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_wr && mem_ready) begin
            if (mem_be[0]) mem_arr[mem_addr[15:1]][7:0] <= mem_wdata[7:0];
            if (mem_be[1]) mem_arr[mem_addr[15:1]][15:8] <= mem_wdata[15:8];
        end
    end

    always @(negedge clk) if (rnd_mode) mem_ready = $urandom_range(3) != 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference behaviour: byte-addressed memory of 16-bit words, updated at issue time.
    function automatic exp_t model(input logic we, size, sext, input logic [15:0] addr, wdata);
        exp_t e;
        logic [15:0] w;
        logic [7:0] b;
        w = ref_mem[addr[15:1]];
        b = addr[0] ? w[15:8] : w[7:0];
        e = '{chk: !we, err: 1'b0, rdata: 16'h0};
        if (size && addr[0]) begin
            e.err = 1'b1;
            e.chk = 1'b1;
        end else if (we) begin
            if (size) ref_mem[addr[15:1]] = wdata;
            else if (addr[0]) ref_mem[addr[15:1]][15:8] = wdata[7:0];
            else ref_mem[addr[15:1]][7:0] = wdata[7:0];
        end else begin
            e.rdata = size ? w : {(sext && b[7]) ? 8'hFF : 8'h00, b};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (f_ack) begin
                if (qf.size() == 0) check("f_unexpected_ack", 1, 0);
                else begin
                    mon_e = qf.pop_front();
                    check("f_err", err, mon_e.err);
                    if (mon_e.chk) check("f_rdata", rdata, mon_e.rdata);
                end
            end
            if (d_ack) begin
                if (qd.size() == 0) check("d_unexpected_ack", 1, 0);
                else begin
                    mon_e = qd.pop_front();
                    check("d_err", err, mon_e.err);
                    if (mon_e.chk) check("d_rdata", rdata, mon_e.rdata);
                end
            end
            if (f_ack || d_ack) check("single_ack", f_ack & d_ack, 0);
            if (mem_rd || mem_wr) check("strobe_excl", mem_rd & mem_wr, 0);
        end
    end

    task automatic access(input logic port, we, size, sext, input logic [15:0] addr, wdata,
                          input bit tmo, input int exp_lat, exp_strb, input logic [1:0] exp_be,
                          input logic [15:0] exp_maddr, exp_mwdata, input string tag);
        int cyc = 0, strb = 0;
        bit done = 0;
        logic [1:0] be_s = '0;
        logic [15:0] a_s = '0, w_s = '0;
        logic wr_s = 0;
        exp_t e;
        @(negedge clk);
        e = tmo ? '{chk: 1'b1, err: 1'b1, rdata: 16'h0} : model(we, size, sext, addr, wdata);
        if (port == PORT_D) begin
            d_req = 1; d_we = we; d_size = size; d_sext = sext; d_addr = addr; d_wdata = wdata;
            qd.push_back(e);
        end else begin
            f_req = 1; f_addr = addr;
            qf.push_back(e);
        end
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_rd || mem_wr) begin
                if (strb == 0) begin be_s = mem_be; a_s = mem_addr; w_s = mem_wdata; wr_s = mem_wr; end
                strb++;
            end
            done = port == PORT_D ? d_ack : f_ack;
        end
        f_req = 0;
        d_req = 0;
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_strobe_cycles"}, strb, exp_strb);
        if (exp_strb > 0) begin
            check({tag, "_be"}, be_s, exp_be);
            check({tag, "_mem_addr"}, a_s, exp_maddr);
            check({tag, "_mem_wr"}, wr_s, we);
            if (we) check({tag, "_mem_wdata"}, w_s, exp_mwdata);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, n;
        logic [7:0] order;
        reset = 0; f_req = 0; d_req = 0; f_addr = 0; d_addr = 0; d_we = 0; d_size = 0;
        d_sext = 0; d_wdata = 0; mem_ready = 1;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem_arr[16'h1800 + i] <= v;
            ref_mem[16'h1800 + i] = v;
            v = 16'($urandom);
            mem_arr[16'h2000 + i] <= v;
            ref_mem[16'h2000 + i] = v;
        end
        repeat (3) @(negedge clk);
        check("rst_ctl", {f_ack, d_ack, err, mem_rd, mem_wr, mem_be}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 1;

        access(PORT_F, 0, 1, 0, 16'h3000, 0, 0, 2, 1, BE_WORD, 16'h3000, 0, "fetch");
        mem_arr[16'h2000] <= 16'h80AA;
        ref_mem[16'h2000] = 16'h80AA;
        access(PORT_D, 0, 0, 1, 16'h4001, 0, 0, 2, 1, BE_HI, 16'h4001, 0, "rdb_sext");
        access(PORT_D, 0, 0, 0, 16'h4001, 0, 0, 2, 1, BE_HI, 16'h4001, 0, "rdb_zext");
        access(PORT_D, 1, 0, 0, 16'h4000, 16'h1234, 0, 2, 1, BE_LO, 16'h4000, 16'h3434, "wrb");
        access(PORT_D, 0, 1, 0, 16'h4000, 0, 0, 2, 1, BE_WORD, 16'h4000, 0, "rdw");
        access(PORT_D, 1, 1, 0, 16'h4002, 16'hBEEF, 0, 2, 1, BE_WORD, 16'h4002, 16'hBEEF, "wrw");
        access(PORT_D, 0, 0, 1, 16'h4003, 0, 0, 2, 1, BE_HI, 16'h4003, 0, "rdb_hi");
        access(PORT_D, 0, 1, 0, 16'h5003, 0, 0, 1, 0, 0, 0, 0, "misalign");
        mem_ready = 0;
        access(PORT_D, 0, 1, 0, 16'h4002, 0, 1, 16, 15, BE_WORD, 16'h4002, 0, "timeout");
        mem_ready = 1;

        // Both ports held: three D grants, then F is forced, repeating.
        @(negedge clk);
        for (int i = 0; i < 2; i++) qf.push_back(model(0, 1, 0, 16'h3002, 0));
        for (int i = 0; i < 6; i++) qd.push_back(model(0, 1, 0, 16'h4004, 0));
        f_req = 1; f_addr = 16'h3002;
        d_req = 1; d_we = 0; d_size = 1; d_sext = 0; d_addr = 16'h4004;
        order = 0; n = 0; cyc = 0;
        while (n < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (f_ack || d_ack) begin order = {order[6:0], d_ack}; n++; end
        end
        f_req = 0; d_req = 0;
        check("grant_order", order, 8'b11101110);

        @(negedge clk);
        mem_ready = 0;
        d_req = 1; d_we = 0; d_size = 1; d_sext = 0; d_addr = 16'h4006;
        repeat (3) @(negedge clk);
        check("rst_pre_strobe", mem_rd, 1);
        reset = 0;
        @(negedge clk);
        check("rst_in_access", {mem_rd, mem_wr, f_ack, d_ack, err, mem_be}, 0);
        @(negedge clk);
        check("rst_hold", {mem_rd, mem_wr, f_ack, d_ack}, 0);
        reset = 1; mem_ready = 1;
        qd.push_back(model(0, 1, 0, 16'h4006, 0));
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!d_ack && cyc < 40);
        d_req = 0;
        check("rst_reservice_latency", cyc, 2);

        rnd_mode = 1;
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    int c;
                    repeat ($urandom_range(3)) @(negedge clk);
                    f_req = 1;
                    f_addr = 16'h3000 | (16'($urandom_range(255)) << 1);
                    qf.push_back(model(0, 1, 0, f_addr, 0));
                    c = 0;
                    do begin @(negedge clk); c++; end while (!f_ack && c < 200);
                    if (!f_ack) check("f_ack_wait", 0, 1);
                    f_req = 0;
                end
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    int c;
                    repeat ($urandom_range(3)) @(negedge clk);
                    d_req = 1;
                    d_we = 1'($urandom_range(1));
                    d_size = 1'($urandom_range(1));
                    d_sext = 1'($urandom_range(1));
                    d_addr = 16'h4000 | 16'($urandom_range(255));
                    d_wdata = 16'($urandom);
                    qd.push_back(model(d_we, d_size, d_sext, d_addr, d_wdata));
                    c = 0;
                    do begin @(negedge clk); c++; end while (!d_ack && c < 200);
                    if (!d_ack) check("d_ack_wait", 0, 1);
                    d_req = 0;
                end
            end
        join
        rnd_mode = 0;
        mem_ready = 1;
        repeat (5) @(negedge clk);
        check("qf_drained", qf.size(), 0);
        check("qd_drained", qd.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_lsb.md
Name: mem_arbiter_lsb

Overview:
- Sequences the single shared LC-3b memory port between two requesters: instruction fetch (port F) and load/store data (port D).
- Performs word/byte lane steering and optional sign extension on byte loads.
- Detects misaligned word accesses and times out hung memory cycles.
- Sits between the controller/MAR-MDR datapath and the memory model; the controller waits on per-port ack instead of fixed cycle counts.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width (two byte lanes; fixed at 16)
TIMEOUT, 15, max cycles in ACCESS waiting for mem_ready before error
FAIR_LIMIT, 3, consecutive D grants allowed while F pending before F is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
f_req  in  1  fetch request, held until f_ack
f_addr  in  ADDR_W  fetch address (always word read)
f_ack  out  1  one-cycle completion pulse for F
d_req  in  1  data request, held until d_ack
d_addr  in  ADDR_W  data address
d_we  in  1  1=write, 0=read
d_size  in  1  1=word, 0=byte
d_sext  in  1  byte read: 1=sign-extend, 0=zero-extend
d_wdata  in  DATA_W  write data (byte in [7:0] when d_size=0)
d_ack  out  1  one-cycle completion pulse for D
rdata  out  DATA_W  read data, valid while f_ack or d_ack
err  out  1  valid with ack: misaligned or timeout
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_be  out  2  byte enables {hi,lo}
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completes access this cycle

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All outputs 0: acks, err, rdata, mem_* strobes, mem_be, mem_addr, mem_wdata.
  - Fairness counter=0, timeout counter=0.
  - Any in-flight access is abandoned; no ack is issued for it.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - Grant rules:
    - d_req only -> grant D.
    - f_req only -> grant F.
    - Both -> grant D, unless fair_cnt==FAIR_LIMIT, then grant F.
  - fair_cnt update: increments on a D grant while f_req=1; clears on any F grant or when f_req=0.
  - On grant, latch port id, addr, we, size, sext, wdata.
  - Misaligned (word size with addr[0]=1): go to RESP with err=1, rdata=0, no memory strobe.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_addr = latched addr with bit0 cleared for word accesses.
  - mem_rd = !we; mem_wr = we.
  - mem_be: word -> 11; byte -> addr[0] ? 10 : 01.
  - Byte write: mem_wdata = {wdata[7:0], wdata[7:0]}. Word write: mem_wdata = wdata.
  - Timeout counter increments each ACCESS cycle without mem_ready.
  - On mem_ready: capture read data, drop strobes next cycle, go to RESP with err=0.
  - If counter reaches TIMEOUT-1 without mem_ready: go to RESP with err=1, rdata=0.
- Read data steering:
  - Word: rdata = mem_rdata.
  - Byte: select lane by addr[0]; extend to 16 bits per sext.
- RESP:
  - Assert ack of the granted port only, for exactly one cycle, together with rdata and err.
  - Next state IDLE.
  - A requester whose req is still high in IDLE is treated as a new request.
- Latency: request sampled at posedge t with zero-wait memory -> strobe high in cycle t+1, ack in cycle t+2. Each mem_ready wait cycle adds one cycle.
- Back-to-back: a minimum of one IDLE cycle separates accesses, so at most one access completes every 3 cycles.
- Strobes are never high in IDLE or RESP; mem_rd and mem_wr are never both high.
- mem_ready outside ACCESS is ignored.
- Request withdrawn before grant: no effect. Withdrawn after grant: the access still completes and is acked.

Decomposition:
- Package lc3b_mem_pkg: state enum (IDLE/ACCESS/RESP), SIZE_BYTE=0 / SIZE_WORD=1, PORT_F=0 / PORT_D=1, BE_LO / BE_HI / BE_WORD constants.
- Sub-module mem_lane_align (combinational): write byte replication, mem_be generation, read lane select and sign/zero extension. Instantiated once.

Test Plan:
- f_req, f_addr=0x3000; mem_ready tied to 1 -> mem_rd high cycle t+1 with mem_addr=0x3000, be=11; f_ack cycle t+2 with rdata=mem_rdata; err=0.
- d_req byte read at addr 0x4001, sext=1, mem_rdata=0x80AA -> be=10, rdata=0xFF80. Same with sext=0 -> rdata=0x0080.
- d_req byte write addr 0x4000, wdata=0x1234 -> mem_wr=1, be=01, mem_wdata=0x3434, d_ack one cycle; f_ack stays 0.
- f_req and d_req held continuously, zero-wait memory -> grant order D,D,D,F,D,D,D,F (FAIR_LIMIT=3).
- Word read at 0x5003 -> no strobe, d_ack with err=1, rdata=0. Separately, mem_ready stuck 0 -> ack with err=1 after 15 ACCESS cycles.
- Reset asserted in ACCESS -> next cycle strobes 0, state IDLE, no ack; a held request is re-serviced normally after reset releases.
